// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake and shared-FIFO write port bundle for fifo_wr_arbiter.
// Producer i's data word sits at bits [i*FIFO_W +: FIFO_W] of req_data.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int FIFO_W  = 32
) ();
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][FIFO_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           fifo_full;
  logic                           fifo_write_en;
  logic [FIFO_W-1:0]              fifo_data_in;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_write_en, fifo_data_in
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_write_en, fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin N-to-1 write arbiter: grants one producer at a time a burst of up
// to MAX_BURST beats into a shared FIFO, with a zero-latency data path.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int FIFO_W    = 32,
  parameter  int MAX_BURST = 4,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              reset,
  fifo_wr_arbiter_if.master bus,
  output logic [GW-1:0]     grant_id,
  output logic              busy,
  output logic [15:0]       write_count
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     last_grant;
  logic [BW-1:0]     beat_cnt;
  logic [FIFO_W-1:0] data_q;
  logic [GW-1:0]     pick, cand;
  logic              pick_ok;
  logic              own_vld, beat, last_beat, burst_end;
  int                idx;

  // Scan downward so the nearest valid requester after last_grant wins.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = '0;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx  = (int'(last_grant) + k) % NUM_REQ;
      cand = GW'(idx);
      if (bus.req_valid[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  assign own_vld   = bus.req_valid[grant_id];
  assign beat      = (state == BURST) && own_vld && !bus.fifo_full;
  assign last_beat = beat && (beat_cnt == BW'(MAX_BURST - 1));
  assign burst_end = (state == BURST) && (last_beat || !own_vld);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pick_ok && !bus.fifo_full) state_nxt = BURST;
      BURST: if (burst_end)                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy              = (state == BURST);
    bus.fifo_write_en = beat;
    bus.fifo_data_in  = beat ? bus.req_data[grant_id] : data_q;
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign bus.req_ready[i] = busy && (grant_id == GW'(i)) && !bus.fifo_full;
  end

  // last_grant resets to the top port so producer 0 wins the first arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant  <= GW'(NUM_REQ - 1);
      grant_id    <= '0;
      beat_cnt    <= '0;
      write_count <= '0;
      data_q      <= '0;
    end else begin
      if (state == IDLE && state_nxt == BURST) begin
        grant_id <= pick;
        beat_cnt <= '0;
      end
      if (beat) begin
        beat_cnt    <= beat_cnt + 1'b1;
        write_count <= write_count + 16'd1;
        data_q      <= bus.req_data[grant_id];
      end
      if (burst_end) last_grant <= grant_id;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a
// burst-level reference model, and a 16-bit write_count wrap run on a second instance.
module tb_fifo_wr_arbiter;
  localparam int NR = 4, W = 32, MB = 4, GW = 2;

  logic clk = 1'b0, reset = 1'b1, wrst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .FIFO_W(W)) bus ();
  logic [GW-1:0] grant_id;
  logic          busy;
  logic [15:0]   write_count;

  fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_W(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .grant_id(grant_id), .busy(busy), .write_count(write_count)
  );

  fifo_wr_arbiter_if #(.NUM_REQ(2), .FIFO_W(8)) wbus ();
  logic        w_gid;
  logic        w_busy;
  logic [15:0] w_wc;

  fifo_wr_arbiter #(.NUM_REQ(2), .FIFO_W(8), .MAX_BURST(64)) u_wrap (
    .clk(clk), .reset(wrst), .bus(wbus),
    .grant_id(w_gid), .busy(w_busy), .write_count(w_wc)
  );

  a_wr_full: assert property (@(posedge clk) disable iff (reset) !(bus.fifo_write_en && bus.fifo_full));
  a_onehot:  assert property (@(posedge clk) disable iff (reset) $onehot0(bus.req_ready));
  a_w_full:  assert property (@(posedge clk) disable iff (wrst) !(wbus.fifo_write_en && wbus.fifo_full));

  int n_chk = 0, n_fail = 0;

  // reference model: current owner (-1 when no burst), beats in burst, last owner
  int          m_owner, m_last, m_beats, m_wc;
  logic [W-1:0] m_data;

  int           cnt   [NR];
  logic [W-1:0] pbase [NR];
  int           gq[$], bl[$], gaps[$], wcq[$];
  logic [W-1:0] wq[$];
  logic         prev_busy;
  int           gap;
  logic         s_we, s_busy;
  logic [NR-1:0] s_rdy;
  bit           wrap_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_data();
    for (int i = 0; i < NR; i++) bus.req_data[i] = pbase[i] + W'(cnt[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_we",    64'(bus.fifo_write_en), 64'd0);
    check("rst_data",  64'(bus.fifo_data_in), 64'd0);
    check("rst_gid",   64'(grant_id), 64'd0);
    check("rst_wc",    64'(write_count), 64'd0);
    m_owner = -1; m_last = NR - 1; m_beats = 0; m_wc = 0; m_data = '0;
    gq.delete(); bl.delete(); gaps.delete(); wcq.delete(); wq.delete();
    prev_busy = 1'b0; gap = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then
  // refresh producer data just after the next rising edge.
  task automatic step();
    logic [NR-1:0] v, exp_rdy;
    logic          f, exp_we;
    logic [W-1:0]  exp_d;
    @(negedge clk);
    v = bus.req_valid;
    f = bus.fifo_full;
    if (m_owner < 0) begin
      exp_rdy = '0; exp_we = 1'b0; exp_d = m_data;
    end else begin
      exp_rdy = f ? '0 : (NR'(1) << m_owner);
      exp_we  = v[m_owner] && !f;
      exp_d   = exp_we ? bus.req_data[m_owner] : m_data;
    end
    s_we = bus.fifo_write_en; s_busy = busy; s_rdy = bus.req_ready;
    check("busy",   64'(busy), 64'(m_owner >= 0));
    if (m_owner >= 0) check("grant_id", 64'(grant_id), 64'(m_owner));
    check("ready",  64'(bus.req_ready), 64'(exp_rdy));
    check("wr_en",  64'(bus.fifo_write_en), 64'(exp_we));
    check("wr_data", 64'(bus.fifo_data_in), 64'(exp_d));
    check("wcount", 64'(write_count), 64'(m_wc));
    check("ready_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
    check("wr_while_full", 64'(bus.fifo_write_en && f), 64'd0);

    if (s_busy) begin
      if (!prev_busy) begin
        if (gq.size() > 0) gaps.push_back(gap);
        gq.push_back(int'(grant_id));
        bl.push_back(0);
        wcq.push_back(int'(write_count));
      end
      gap = 0;
    end else gap++;
    if (s_we) begin
      wq.push_back(bus.fifo_data_in);
      if (bl.size() > 0) bl[bl.size()-1]++;
    end
    prev_busy = s_busy;

    if (m_owner < 0) begin
      if (v != '0 && !f) begin
        for (int k = 1; k <= NR; k++) begin
          int c;
          c = (m_last + k) % NR;
          if (v[c]) begin m_owner = c; break; end
        end
        m_beats = 0;
      end
    end else if (exp_we) begin
      m_beats++;
      m_wc   = (m_wc + 1) % 65536;
      m_data = bus.req_data[m_owner];
      if (m_beats == MB) begin m_last = m_owner; m_owner = -1; end
    end else if (!v[m_owner]) begin
      m_last = m_owner; m_owner = -1;
    end

    for (int i = 0; i < NR; i++) if (v[i] && s_rdy[i]) cnt[i]++;
    @(posedge clk); #1;
    set_data();
  endtask

  task automatic prep(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) begin cnt[i] = 0; pbase[i] = W'(i) << 28; end
    bus.req_valid = v;
    bus.fifo_full = 1'b0;
  endtask

  initial begin
    int phase;
    bus.req_valid = '0; bus.fifo_full = 1'b0; bus.req_data = '0;

    // single producer, 6 beats: 4-beat burst, one idle cycle, 2-beat burst
    prep(4'b0001);
    pbase[0] = 32'h126598AB;
    set_data();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if (wq.size() >= 6) bus.req_valid = '0;
      step();
    end
    check("s1_wcount", 64'(write_count), 64'd6);
    check("s1_bursts", 64'(gq.size()), 64'd2);
    if (gq.size() == 2) begin
      check("s1_gid0", 64'(gq[0]), 64'd0);
      check("s1_gid1", 64'(gq[1]), 64'd0);
      check("s1_len0", 64'(bl[0]), 64'd4);
      check("s1_len1", 64'(bl[1]), 64'd2);
      check("s1_gap",  64'(gaps[0]), 64'd1);
    end
    for (int k = 0; k < 6 && k < wq.size(); k++)
      check("s1_data", 64'(wq[k]), 64'(32'h126598AB + k));

    // all producers valid: rotation 0,1,2,3,0, 4 beats each, 1 idle between
    prep(4'b1111);
    set_data();
    do_reset();
    for (int i = 0; i < 60 && !(gq.size() >= 5 && bl[4] >= 4); i++) step();
    check("s2_bursts", 64'(gq.size()), 64'd5);
    for (int k = 0; k < 5 && k < gq.size(); k++) begin
      check("s2_gid", 64'(gq[k]), 64'(k % NR));
      check("s2_len", 64'(bl[k]), 64'd4);
    end
    for (int k = 0; k < 4 && k < gaps.size(); k++) check("s2_gap", 64'(gaps[k]), 64'd1);

    // producer 2 stalled by fifo_full for 3 cycles after its first beat
    prep(4'b0100);
    set_data();
    do_reset();
    phase = 0;
    for (int i = 0; i < 30; i++) begin
      if (phase == 0 && wq.size() == 1) phase = 1;
      bus.fifo_full = (phase >= 1 && phase <= 3);
      if (wq.size() >= 4) bus.req_valid = '0;
      step();
      if (phase >= 1 && phase <= 3) begin
        check("s3_stall_we",   64'(s_we), 64'd0);
        check("s3_stall_rdy",  64'(s_rdy), 64'd0);
        check("s3_stall_busy", 64'(s_busy), 64'd1);
        phase++;
      end
    end
    bus.fifo_full = 1'b0;
    check("s3_stalls", 64'(phase), 64'd4);
    check("s3_bursts", 64'(gq.size()), 64'd1);
    if (gq.size() == 1) begin
      check("s3_gid", 64'(gq[0]), 64'd2);
      check("s3_len", 64'(bl[0]), 64'd4);
    end
    check("s3_beats", 64'(wq.size()), 64'd4);
    for (int k = 0; k < 4 && k < wq.size(); k++)
      check("s3_data", 64'(wq[k]), 64'(32'h2000_0000 + k));

    // producer 1 drops valid after 2 beats; producer 3 takes over
    prep(4'b1010);
    set_data();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (wq.size() >= 2) bus.req_valid = 4'b1000;
      step();
    end
    bus.req_valid = '0;
    repeat (2) step();
    check("s4_bursts_ge2", 64'(gq.size() >= 2), 64'd1);
    if (gq.size() >= 2) begin
      check("s4_gid0",  64'(gq[0]), 64'd1);
      check("s4_len0",  64'(bl[0]), 64'd2);
      check("s4_gid1",  64'(gq[1]), 64'd3);
      check("s4_wc_at", 64'(wcq[1]), 64'd2);
    end

    // reset mid-burst of producer 3; producer 0 wins next despite 3 valid
    prep(4'b1000);
    set_data();
    do_reset();
    for (int i = 0; i < 20 && wq.size() < 2; i++) step();
    bus.req_valid = 4'b1001;
    check("s5_busy_pre", 64'(busy), 64'd1);
    check("s5_gid_pre",  64'(grant_id), 64'd3);
    do_reset();
    for (int i = 0; i < 10 && gq.size() == 0; i++) step();
    check("s5_regrant", 64'(gq.size()), 64'd1);
    if (gq.size() >= 1) check("s5_gid", 64'(gq[0]), 64'd0);
    bus.req_valid = '0;
    repeat (2) step();

    // random traffic and backpressure
    prep(NR'($urandom));
    for (int i = 0; i < NR; i++) pbase[i] = $urandom;
    set_data();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < NR; p++)
        if ($urandom_range(3) == 0) bus.req_valid[p] = ~bus.req_valid[p];
      bus.fifo_full = ($urandom_range(3) == 0);
      step();
    end
    bus.req_valid = '0; bus.fifo_full = 1'b0;

    for (int i = 0; i < 80000 && !wrap_done; i++) @(posedge clk);
    if (!wrap_done) check("wrap_timeout", 64'd0, 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // 65538 beats from producer 0 through the wide-burst instance
  initial begin
    int nw, budget;
    nw = 0; budget = 0;
    wbus.req_valid = '0; wbus.req_data = '0; wbus.fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("wrap_rst_wc", 64'(w_wc), 64'd0);
    wrst = 1'b0;
    wbus.req_valid = 2'b01;
    while (nw < 65538 && budget < 70000) begin
      @(negedge clk);
      budget++;
      if (wbus.fifo_write_en) nw++;
    end
    @(posedge clk); #1;
    wbus.req_valid = '0;
    @(negedge clk);
    check("wrap_beats", 64'(nw), 64'd65538);
    check("wrap_wc",    64'(w_wc), 64'd2);
    check("wrap_gid",   64'(w_gid), 64'd0);
    wrap_done = 1'b1;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Parameters
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of producer ports.
REQ-002 The block SHALL have parameter FIFO_W, default 32, giving the data word width.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, giving the maximum consecutive beats per grant.

Interface
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  NUM_REQ  per-producer data-valid.
REQ-008 req_data  in  NUM_REQ*FIFO_W  per-producer data; producer i occupies bits [i*FIFO_W +: FIFO_W].
REQ-009 req_ready  out  NUM_REQ  per-producer accept; at most one bit is high at a time.
REQ-010 fifo_full  in  1  full flag from the shared FIFO.
REQ-011 fifo_write_en  out  1  write strobe to the FIFO.
REQ-012 fifo_data_in  out  FIFO_W  write data to the FIFO.
REQ-013 grant_id  out  clog2(NUM_REQ)  current burst owner; valid while busy=1.
REQ-014 busy  out  1  high in state BURST.
REQ-015 write_count  out  16  total accepted beats; wraps from 16'hFFFF to 0.

Function
REQ-016 The FSM SHALL have two states: IDLE and BURST.
REQ-017 In IDLE, when any req_valid is high and fifo_full=0, the block SHALL select the first valid requester after last_grant in ascending modulo-NUM_REQ order, load grant_id with it, clear beat_cnt, and enter BURST on the next edge.
REQ-018 In IDLE, when fifo_full=1 or no req_valid is high, the block SHALL stay in IDLE; no data is transferred in any IDLE cycle.
REQ-019 In BURST: req_ready[grant_id] = !fifo_full (combinational); all other req_ready bits = 0.
REQ-020 A beat SHALL transfer in a cycle where req_valid[grant_id] and req_ready[grant_id] are both high; in that cycle fifo_write_en=1 and fifo_data_in = req_data slice of grant_id. Both outputs are combinational: zero-cycle latency from producer to FIFO.
REQ-021 When no beat transfers, fifo_write_en SHALL be 0 and fifo_data_in SHALL hold its previous registered value.
REQ-022 Each transferred beat SHALL increment beat_cnt and write_count by 1.
REQ-023 The burst SHALL end, with return to IDLE and last_grant set to grant_id, on the first of: (a) a transfer that makes beat_cnt = MAX_BURST; (b) a BURST cycle with req_valid[grant_id]=0.
REQ-024 fifo_full=1 with req_valid[grant_id]=1 SHALL stall the burst: the state stays BURST, beat_cnt is held, and no write occurs.
REQ-025 Rotation SHALL be starvation-free: with all producers continuously valid, grants cycle 0,1,...,NUM_REQ-1,0.
REQ-026 The block SHALL never assert fifo_write_en while fifo_full=1.

Reset
REQ-027 While reset=1, the block SHALL force: state=IDLE, last_grant=NUM_REQ-1 (producer 0 wins first), beat_cnt=0, grant_id=0, busy=0, req_ready=0, fifo_write_en=0, fifo_data_in=0, write_count=0.
REQ-028 Reset asserted mid-burst SHALL abort the burst immediately (asynchronously); the partial beats already written stay in the FIFO and are counted by the FIFO, not by the block.

Verification
REQ-029 After reset, req_valid=4'b0001, 6 beats 32'h126598AB.. -> grant_id=0; 4 writes; then IDLE for 1 cycle; then 2 writes; write_count=6.
REQ-030 All req_valid=4'b1111, continuously valid, fifo_full=0 -> grant_id sequence 0,1,2,3,0, each with 4 beats; bursts separated by one IDLE cycle.
REQ-031 fifo_full raised for 3 cycles mid-burst of producer 2 -> fifo_write_en=0 and req_ready=0 for exactly those 3 cycles; beat_cnt is held; the burst resumes at the next beat; no beat is lost or duplicated.
REQ-032 Producer 1 drops req_valid after 2 beats while req_valid[3]=1 -> return to IDLE; next grant_id=3; write_count increments by 2 for producer 1.
REQ-033 reset pulsed during a BURST of producer 3 -> all outputs are 0 in the same cycle; the next grant goes to producer 0 even though producers 0 and 3 are both valid.
REQ-034 65538 beats are streamed -> write_count wraps to 2; an assertion checks that fifo_write_en and fifo_full are never both high, and that $onehot0(req_ready) holds in every cycle.
